// File: rtl/mux4_rr_sched.sv
// mux4_rr_sched
// -------------
// Round-robin scheduler that shares one single-bit 4:1 mux channel among four
// requesters. Each grant is held for at most BURST consecutive cycles and then
// rotates, so no requester can starve the others.
//
// Handshake: req[k] is a level-sensitive request. Requester k owns the channel
// in every cycle where gnt[k]=1. valid is high exactly when some gnt bit is
// set. A requester releases the channel by dropping req[k]. The scheduler sees
// the drop at the next rising edge, so gnt[k] stays high for one cycle after
// the drop.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   en       scheduler enable; 0 releases the current grant and blocks new ones
//   req[3:0] per-requester request, level-sensitive
//   i0..i3   data bit from each requester
//   gnt[3:0] one-hot grant, registered (all zeros when idle)
//   s1, s0   registered mux select; {s1,s0} = granted index
//   valid    channel owned this cycle (= |gnt), registered
//   y        combinational: valid ? i[{s1,s0}] : 0
//
// The FSM state is state_q (typedef state_e). It is visible hierarchically to
// checkers.

module mux4_rr_sched #(
  parameter int BURST = 4,
  parameter int CNT_W = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] req,
  input  logic       i0,
  input  logic       i1,
  input  logic       i2,
  input  logic       i3,
  output logic [3:0] gnt,
  output logic       s1,
  output logic       s0,
  output logic       valid,
  output logic       y
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] BURST_C = CNT_W'(BURST);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  state_e           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       sel_q, sel_d;
  logic             valid_q, valid_d;

  logic [2:0]       win;        // {found, index}
  logic [1:0]       next_ptr;
  logic [3:0]       i_vec;

  // Scan from the pointer position upward, with wrap from 3 to 0. The loop
  // visits the offsets from highest to lowest. The last hit is written last,
  // so the hit nearest the pointer is the one kept.
  function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = p + 2'(i);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign next_ptr = sel_q + 2'd1;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    win     = 3'b000;

    case (state_q)
      IDLE: begin
        win = pick(req, ptr_q);
        if (en && win[2]) begin
          state_d = GRANT;
          gnt_d   = 4'b0001 << win[1:0];
          sel_d   = win[1:0];
          valid_d = 1'b1;
          cnt_d   = ONE_C;
        end
      end
      GRANT: begin
        if (en && req[sel_q] && (cnt_q < BURST_C)) begin
          cnt_d = cnt_q + ONE_C;
        end else begin
          // Release. The search starts one past the current owner, so a sole
          // requester that hits BURST wraps back to itself with no idle gap.
          ptr_d = next_ptr;
          win   = pick(req, next_ptr);
          if (en && win[2]) begin
            gnt_d   = 4'b0001 << win[1:0];
            sel_d   = win[1:0];
            valid_d = 1'b1;
            cnt_d   = ONE_C;
          end else begin
            // The selects keep their last value. Only gnt and valid drop.
            state_d = IDLE;
            gnt_d   = 4'b0000;
            valid_d = 1'b0;
            cnt_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      cnt_q   <= '0;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
    end
  end

  assign i_vec = {i3, i2, i1, i0};
  assign gnt   = gnt_q;
  assign s1    = sel_q[1];
  assign s0    = sel_q[0];
  assign valid = valid_q;
  assign y     = valid_q & i_vec[sel_q];

endmodule

// File: tb/tb_mux4_rr_sched.sv
// Directed bench for mux4_rr_sched (BURST=4). Expected values are hand-derived.
module tb_mux4_rr_sched;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] req;
  logic       i0, i1, i2, i3;
  logic [3:0] gnt;
  logic       s1, s0, valid, y;

  int n_chk  = 0;
  int n_pass = 0;

  mux4_rr_sched #(.BURST(4), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .req   (req),
    .i0    (i0),
    .i1    (i1),
    .i2    (i2),
    .i3    (i3),
    .gnt   (gnt),
    .s1    (s1),
    .s0    (s0),
    .valid (valid),
    .y     (y)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, landing 1 time unit after the last edge.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Check all registered outputs at once.
  task automatic chk_out(input string tag, input logic [3:0] eg, input logic [1:0] es,
                         input logic ev);
    chk({tag, ".gnt"}, gnt, eg);
    chk({tag, ".sel"}, {2'b00, s1, s0}, {2'b00, es});
    chk({tag, ".valid"}, {3'b000, valid}, {3'b000, ev});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(1);
  endtask

  initial begin
    logic [3:0] eg;
    logic [1:0] es;

    rst_n = 1'b0; en = 1'b0; req = 4'b0000;
    {i3, i2, i1, i0} = 4'b0000;
    #1;
    chk_out("reset", 4'b0000, 2'b00, 1'b0);
    chk("reset.y", {3'b000, y}, 4'b0000);
    tick(2);
    rst_n = 1'b1;
    en    = 1'b1;
    tick(2);
    chk_out("idle_noreq", 4'b0000, 2'b00, 1'b0);

    // Single requester: req=0100 held, re-granted at burst end with no gap.
    req = 4'b0100;
    for (int t = 1; t <= 10; t++) begin
      tick(1);
      chk_out($sformatf("single.c%0d", t), 4'b0100, 2'b10, 1'b1);
    end
    req = 4'b0000;
    tick(1);
    chk_out("single.drop", 4'b0000, 2'b10, 1'b0);

    // Async reset mid-grant (ptr=3 now; search 3,0,1,2 -> 2).
    req = 4'b0100;
    i2  = 1'b1;
    tick(1);
    chk_out("pre_rst", 4'b0100, 2'b10, 1'b1);
    chk("pre_rst.y", {3'b000, y}, 4'b0001);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("async_rst", 4'b0000, 2'b00, 1'b0);
    chk("async_rst.y", {3'b000, y}, 4'b0000);
    req = 4'b0000;
    i2  = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(2);
    chk_out("post_rst", 4'b0000, 2'b00, 1'b0);

    // Full load from ptr=0: 0,1,2,3,0, each 4 cycles, no valid gap.
    req = 4'b1111;
    for (int t = 1; t <= 20; t++) begin
      tick(1);
      es = 2'((t - 1) / 4);
      eg = 4'b0001 << es;
      chk_out($sformatf("full.c%0d", t), eg, es, 1'b1);
    end
    req = 4'b0000;
    tick(1);
    chk_out("full.end", 4'b0000, 2'b00, 1'b0);

    // Wrap: req=1001 from reset -> 0 (4), 3 (4), 0.
    do_reset();
    req = 4'b1001;
    for (int t = 1; t <= 12; t++) begin
      tick(1);
      if (t >= 5 && t <= 8) begin
        eg = 4'b1000; es = 2'b11;
      end else begin
        eg = 4'b0001; es = 2'b00;
      end
      chk_out($sformatf("wrap.c%0d", t), eg, es, 1'b1);
    end
    req = 4'b0000;
    tick(1);

    // Early drop: grant 1, drop after 2 cycles. Search restarts at 2 -> 3 beats 0.
    do_reset();
    req = 4'b0010;
    tick(1);
    chk_out("drop.g1a", 4'b0010, 2'b01, 1'b1);
    tick(1);
    chk_out("drop.g1b", 4'b0010, 2'b01, 1'b1);
    req = 4'b1001;
    tick(1);
    chk_out("drop.next", 4'b1000, 2'b11, 1'b1);

    // en low mid-grant -> IDLE at the next edge, selects hold.
    en = 1'b0;
    tick(1);
    chk_out("en_off", 4'b0000, 2'b11, 1'b0);
    req = 4'b0010;
    tick(1);
    chk_out("en_off_hold", 4'b0000, 2'b11, 1'b0);
    en = 1'b1;
    tick(1);
    chk_out("en_on", 4'b0010, 2'b01, 1'b1);

    // Data path: move the grant to index 3 (release from 1, search 2,3 -> 3).
    req = 4'b1000;
    {i3, i2, i1, i0} = 4'b0111;
    tick(1);
    chk_out("dp.g3", 4'b1000, 2'b11, 1'b1);
    chk("dp.y0", {3'b000, y}, 4'b0000);
    i3 = 1'b1;
    #1;
    chk("dp.y1", {3'b000, y}, 4'b0001);
    i3 = 1'b0;
    #1;
    chk("dp.y2", {3'b000, y}, 4'b0000);
    req = 4'b0000;
    tick(1);
    {i3, i2, i1, i0} = 4'b1111;
    #1;
    chk("dp.novalid", {3'b000, valid, 3'b000, y}, 8'h00);
    chk("dp.novalid_y", {3'b000, y}, 4'b0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, observed hang expected finish");
    $fatal(1, "timeout");
  end

endmodule
